// File: rtl/grid_pkg.sv
// Shared definitions for the kitchen grid renderer and the compositor.
// Holds the object codes, the object palette, the fixed colours used by the
// tile shader, the grid geometry, and a helper that maps a code to its colour.
package grid_pkg;

    // Grid geometry
    localparam int GRID_X0   = 112;
    localparam int GRID_Y0   = 112;
    localparam int CELL_LOG2 = 5;
    localparam int COLS      = 8;
    localparam int ROWS      = 13;

    // Last pixel column/row that still lies inside the grid
    localparam logic [10:0] GRID_X_FIRST = 11'(GRID_X0);
    localparam logic [10:0] GRID_X_LAST  = 11'(GRID_X0 + (COLS << CELL_LOG2) - 1);
    localparam logic [9:0]  GRID_Y_FIRST = 10'(GRID_Y0);
    localparam logic [9:0]  GRID_Y_LAST  = 10'(GRID_Y0 + (ROWS << CELL_LOG2) - 1);

    typedef enum logic [3:0] {
        G_EMPTY         = 4'd0,
        G_ONION_WHOLE   = 4'd1,
        G_ONION_CHOPPED = 4'd2,
        G_BOWL_EMPTY    = 4'd3,
        G_BOWL_FULL     = 4'd4,
        G_POT_EMPTY     = 4'd5,
        G_POT_RAW       = 4'd6,
        G_POT_COOKED    = 4'd7,
        G_FIRE          = 4'd8,
        G_POT_FIRE      = 4'd9,
        G_EXTINGUISHER  = 4'd10
    } obj_code_t;

    // Object palette (RGB444)
    localparam logic [11:0] C_ONION_WHOLE   = 12'hF8F;
    localparam logic [11:0] C_ONION_CHOPPED = 12'hFCF;
    localparam logic [11:0] C_BOWL_EMPTY    = 12'hFFF;
    localparam logic [11:0] C_BOWL_FULL     = 12'hFA0;
    localparam logic [11:0] C_POT_EMPTY     = 12'h888;
    localparam logic [11:0] C_POT_RAW       = 12'h8A8;
    localparam logic [11:0] C_POT_COOKED    = 12'hA60;
    localparam logic [11:0] C_EXTINGUISHER  = 12'hF00;
    localparam logic [11:0] C_FIRE_A        = 12'hF00;
    localparam logic [11:0] C_FIRE_B        = 12'hF80;

    // Tile furniture
    localparam logic [11:0] C_BAR           = 12'h0F0;
    localparam logic [11:0] C_BORDER        = 12'h444;
    localparam logic [11:0] C_COUNTER       = 12'h864;

    // Colour of a defined object; blink selects the alternate flame colour.
    function automatic logic [11:0] obj_color(input logic [3:0] code, input logic blink);
        logic [11:0] c;
        case (code)
            G_ONION_WHOLE:   c = C_ONION_WHOLE;
            G_ONION_CHOPPED: c = C_ONION_CHOPPED;
            G_BOWL_EMPTY:    c = C_BOWL_EMPTY;
            G_BOWL_FULL:     c = C_BOWL_FULL;
            G_POT_EMPTY:     c = C_POT_EMPTY;
            G_POT_RAW:       c = C_POT_RAW;
            G_POT_COOKED:    c = C_POT_COOKED;
            G_FIRE,
            G_POT_FIRE:      c = blink ? C_FIRE_B : C_FIRE_A;
            G_EXTINGUISHER:  c = C_EXTINGUISHER;
            default:         c = C_COUNTER;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/grid_tile_renderer_tile_shader.sv
// Combinational colour of one pixel inside a grid cell.
// Ports:
//   code  - object code of the cell
//   t     - cook/chop progress 0..15
//   ox/oy - pixel offset within the 32x32 cell
//   blink - flame colour select
//   color - RGB444 result (border/background when nothing else covers it)
module tile_shader
    import grid_pkg::*;
(
    input  logic [3:0]  code,
    input  logic [3:0]  t,
    input  logic [4:0]  ox,
    input  logic [4:0]  oy,
    input  logic        blink,
    output logic [11:0] color
);

    logic [4:0] adx;
    logic [4:0] ady;
    logic [9:0] dist2;
    logic [5:0] bar_end;
    logic       in_bar;
    logic       known;
    logic       round_obj;
    logic       in_circle;
    logic       in_square;
    logic       in_obj;

    always_comb begin
        adx       = (ox >= 5'd16) ? (ox - 5'd16) : (5'd16 - ox);
        ady       = (oy >= 5'd16) ? (oy - 5'd16) : (5'd16 - oy);
        dist2     = ({5'd0, adx} * {5'd0, adx}) + ({5'd0, ady} * {5'd0, ady});

        // Bar covers ox in [2, 2+2t); 6 bits so t=15 reaches 32 exclusive.
        bar_end   = 6'd2 + {1'b0, t, 1'b0};
        in_bar    = (t != 4'd0) && ((oy == 5'd28) || (oy == 5'd29))
                    && (ox >= 5'd2) && ({1'b0, ox} < bar_end);

        // Codes 11..15 are undefined and fall through to the background.
        known     = (code != G_EMPTY) && (code <= G_EXTINGUISHER);
        round_obj = (code == G_ONION_WHOLE) || (code == G_ONION_CHOPPED);
        in_circle = (dist2 <= 10'd100);
        in_square = (ox >= 5'd6) && (ox <= 5'd25) && (oy >= 5'd6) && (oy <= 5'd25);
        in_obj    = known && (round_obj ? in_circle : in_square);

        if (in_bar)
            color = C_BAR;
        else if (in_obj)
            color = obj_color(code, blink);
        else if ((ox == 5'd0) || (oy == 5'd0))
            color = C_BORDER;
        else
            color = C_COUNTER;
    end

endmodule

// File: rtl/grid_tile_renderer.sv
// Pipelined pixel source for the kitchen grid (3-cycle latency).
// S1 locates the pixel in the grid, S2 fetches the cell's object code and
// timer, S3 shades the pixel. Sync and blank ride along the same pipeline.
// Ports:
//   clock, reset           - pixel clock, async active-high reset
//   hcount, vcount         - current XVGA pixel position
//   hsync, vsync, blank    - XVGA timing (syncs active low)
//   object_grid, time_grid - per-cell object code / progress, [col][row]
//   pixel_out              - RGB444 grid pixel, 0 outside grid or in blank
//   in_grid_out            - pixel lies inside the grid area
//   hsync_out, vsync_out, blank_out - timing delayed 3 cycles
module grid_tile_renderer
    import grid_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [10:0]            hcount,
    input  logic [9:0]             vcount,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic                   blank,
    input  logic [7:0][12:0][3:0]  object_grid,
    input  logic [7:0][12:0][3:0]  time_grid,
    output logic [11:0]            pixel_out,
    output logic                   in_grid_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   blank_out
);

    // S1 combinational locate
    logic        in_grid;
    logic [10:0] hx;
    logic [10:0] vy;
    logic        unused_bits;

    always_comb begin
        in_grid = (hcount >= GRID_X_FIRST) && (hcount <= GRID_X_LAST)
                  && (vcount >= GRID_Y_FIRST) && (vcount <= GRID_Y_LAST);
        hx      = hcount - GRID_X_FIRST;
        vy      = {1'b0, vcount} - {1'b0, GRID_Y_FIRST};
    end

    // Offsets inside the grid never exceed 255 x 415.
    assign unused_bits = ^{hx[10:8], vy[10:9]};

    logic [2:0]  s1_col;
    logic [3:0]  s1_row;
    logic [4:0]  s1_ox, s1_oy;
    logic        s1_in_grid, s1_hsync, s1_vsync, s1_blank;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_col     <= '0;
            s1_row     <= '0;
            s1_ox      <= '0;
            s1_oy      <= '0;
            s1_in_grid <= 1'b0;
            s1_hsync   <= 1'b1;
            s1_vsync   <= 1'b1;
            s1_blank   <= 1'b1;
        end else begin
            // Out-of-grid positions are zeroed so they can never index past the arrays.
            s1_col     <= in_grid ? hx[7:5] : 3'd0;
            s1_row     <= in_grid ? vy[8:5] : 4'd0;
            s1_ox      <= in_grid ? hx[4:0] : 5'd0;
            s1_oy      <= in_grid ? vy[4:0] : 5'd0;
            s1_in_grid <= in_grid;
            s1_hsync   <= hsync;
            s1_vsync   <= vsync;
            s1_blank   <= blank;
        end
    end

    // S2 fetch
    logic [3:0]  s2_code, s2_t;
    logic [4:0]  s2_ox, s2_oy;
    logic        s2_in_grid, s2_hsync, s2_vsync, s2_blank;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_code    <= '0;
            s2_t       <= '0;
            s2_ox      <= '0;
            s2_oy      <= '0;
            s2_in_grid <= 1'b0;
            s2_hsync   <= 1'b1;
            s2_vsync   <= 1'b1;
            s2_blank   <= 1'b1;
        end else begin
            s2_code    <= s1_in_grid ? object_grid[s1_col][s1_row] : 4'd0;
            s2_t       <= s1_in_grid ? time_grid[s1_col][s1_row]   : 4'd0;
            s2_ox      <= s1_ox;
            s2_oy      <= s1_oy;
            s2_in_grid <= s1_in_grid;
            s2_hsync   <= s1_hsync;
            s2_vsync   <= s1_vsync;
            s2_blank   <= s1_blank;
        end
    end

    // Frame counter for the flame animation, advanced on vsync falling edges
    logic [7:0] frame_count;
    logic       vsync_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
            vsync_prev  <= 1'b1;
        end else begin
            vsync_prev <= vsync;
            if (vsync_prev && !vsync)
                frame_count <= frame_count + 8'd1;
        end
    end

    // S3 shade
    logic [11:0] shade;

    tile_shader u_tile_shader (
        .code  (s2_code),
        .t     (s2_t),
        .ox    (s2_ox),
        .oy    (s2_oy),
        .blink (frame_count[3]),
        .color (shade)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_out   <= '0;
            in_grid_out <= 1'b0;
            hsync_out   <= 1'b1;
            vsync_out   <= 1'b1;
            blank_out   <= 1'b1;
        end else begin
            pixel_out   <= (s2_blank || !s2_in_grid) ? 12'h000 : shade;
            in_grid_out <= s2_in_grid;
            hsync_out   <= s2_hsync;
            vsync_out   <= s2_vsync;
            blank_out   <= s2_blank;
        end
    end

endmodule

// File: tb/tb_grid_tile_renderer.sv
module tb_grid_tile_renderer;
    import grid_pkg::*;

    logic                  clock;
    logic                  reset;
    logic [10:0]           hcount;
    logic [9:0]            vcount;
    logic                  hsync, vsync, blank;
    logic [7:0][12:0][3:0] object_grid;
    logic [7:0][12:0][3:0] time_grid;
    logic [11:0]           pixel_out;
    logic                  in_grid_out, hsync_out, vsync_out, blank_out;

    int checks;
    int errors;

    grid_tile_renderer dut (
        .clock       (clock),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .object_grid (object_grid),
        .time_grid   (time_grid),
        .pixel_out   (pixel_out),
        .in_grid_out (in_grid_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .blank_out   (blank_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one pixel position and wait until its result reaches the outputs.
    task automatic put_pixel(input int h, input int v);
        @(negedge clock);
        hcount = 11'(h);
        vcount = 10'(v);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic vsync_pulse();
        @(negedge clock);
        vsync = 1'b0;
        @(negedge clock);
        vsync = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        hcount = 11'd200; vcount = 10'd200;
        hsync = 1'b0; vsync = 1'b0; blank = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (pixel_out !== 12'h864) begin
            errors++; $display("FAIL rst_prefill pixel: got %h expected %h", pixel_out, 12'h864);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({pixel_out, in_grid_out, hsync_out, vsync_out, blank_out} !== {12'h000, 4'b0111}) begin
            errors++; $display("FAIL rst_async: got pix=%h ig=%b hs=%b vs=%b bl=%b expected 000 0 1 1 1",
                               pixel_out, in_grid_out, hsync_out, vsync_out, blank_out);
        end
        @(posedge clock); #1;
        checks++;
        if ({pixel_out, hsync_out, vsync_out, blank_out} !== {12'h000, 3'b111}) begin
            errors++; $display("FAIL rst_held: got pix=%h hs=%b vs=%b bl=%b expected 000 1 1 1",
                               pixel_out, hsync_out, vsync_out, blank_out);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (pixel_out !== 12'h000 || hsync_out !== 1'b1) begin
            errors++; $display("FAIL rst_rel1: got pix=%h hs=%b expected 000 1", pixel_out, hsync_out);
        end
        @(posedge clock); #1;
        checks++;
        if (pixel_out !== 12'h000 || hsync_out !== 1'b1) begin
            errors++; $display("FAIL rst_rel2: got pix=%h hs=%b expected 000 1", pixel_out, hsync_out);
        end
        @(posedge clock); #1;
        checks++;
        if (pixel_out !== 12'h864 || hsync_out !== 1'b0 || in_grid_out !== 1'b1) begin
            errors++; $display("FAIL rst_rel3: got pix=%h hs=%b ig=%b expected 864 0 1",
                               pixel_out, hsync_out, in_grid_out);
        end
        @(negedge clock);
        hsync = 1'b1; vsync = 1'b1;
    endtask

    task automatic test_boundary();
        put_pixel(367, 527);
        checks++;
        if (in_grid_out !== 1'b1 || pixel_out !== 12'h864) begin
            errors++; $display("FAIL bnd_last: got ig=%b pix=%h expected 1 864", in_grid_out, pixel_out);
        end
        put_pixel(368, 300);
        checks++;
        if (in_grid_out !== 1'b0 || pixel_out !== 12'h000) begin
            errors++; $display("FAIL bnd_right: got ig=%b pix=%h expected 0 000", in_grid_out, pixel_out);
        end
        put_pixel(111, 300);
        checks++;
        if (in_grid_out !== 1'b0 || pixel_out !== 12'h000) begin
            errors++; $display("FAIL bnd_left: got ig=%b pix=%h expected 0 000", in_grid_out, pixel_out);
        end
        put_pixel(200, 528);
        checks++;
        if (in_grid_out !== 1'b0 || pixel_out !== 12'h000) begin
            errors++; $display("FAIL bnd_bottom: got ig=%b pix=%h expected 0 000", in_grid_out, pixel_out);
        end
        put_pixel(112, 112);
        checks++;
        if (in_grid_out !== 1'b1 || pixel_out !== 12'h444) begin
            errors++; $display("FAIL bnd_first: got ig=%b pix=%h expected 1 444", in_grid_out, pixel_out);
        end
    endtask

    task automatic test_onion();
        object_grid[0][0] = G_ONION_WHOLE;
        put_pixel(128, 128);
        checks++;
        if (pixel_out !== 12'hF8F || in_grid_out !== 1'b1) begin
            errors++; $display("FAIL onion_centre: got pix=%h ig=%b expected F8F 1", pixel_out, in_grid_out);
        end
        put_pixel(112, 140);
        checks++;
        if (pixel_out !== 12'h444) begin
            errors++; $display("FAIL onion_border: got %h expected 444", pixel_out);
        end
        blank = 1'b1;
        put_pixel(128, 128);
        checks++;
        if (pixel_out !== 12'h000) begin
            errors++; $display("FAIL onion_blank: got %h expected 000", pixel_out);
        end
        blank = 1'b0;
    endtask

    task automatic test_objects();
        object_grid[3][0] = G_POT_COOKED;
        object_grid[4][0] = G_ONION_CHOPPED;
        object_grid[1][1] = 4'd11;
        time_grid[5][0]   = 4'd15;
        put_pixel(214, 118);
        checks++;
        if (pixel_out !== 12'hA60) begin
            errors++; $display("FAIL pot_corner: got %h expected A60", pixel_out);
        end
        put_pixel(213, 118);
        checks++;
        if (pixel_out !== 12'h864) begin
            errors++; $display("FAIL pot_outside: got %h expected 864", pixel_out);
        end
        put_pixel(266, 128);
        checks++;
        if (pixel_out !== 12'hFCF) begin
            errors++; $display("FAIL chopped_rim: got %h expected FCF", pixel_out);
        end
        put_pixel(267, 128);
        checks++;
        if (pixel_out !== 12'h864) begin
            errors++; $display("FAIL chopped_out: got %h expected 864", pixel_out);
        end
        put_pixel(160, 160);
        checks++;
        if (pixel_out !== 12'h864) begin
            errors++; $display("FAIL undef_code: got %h expected 864", pixel_out);
        end
        put_pixel(303, 141);
        checks++;
        if (pixel_out !== 12'h0F0) begin
            errors++; $display("FAIL bar_t15_end: got %h expected 0F0", pixel_out);
        end
        put_pixel(273, 141);
        checks++;
        if (pixel_out !== 12'h864) begin
            errors++; $display("FAIL bar_t15_ox1: got %h expected 864", pixel_out);
        end
    endtask

    task automatic test_progress_bar();
        time_grid[7][12] = 4'd3;
        put_pixel(343, 524);
        checks++;
        if (pixel_out !== 12'h0F0) begin
            errors++; $display("FAIL bar_t3_ox7: got %h expected 0F0", pixel_out);
        end
        put_pixel(344, 524);
        checks++;
        if (pixel_out !== 12'h864) begin
            errors++; $display("FAIL bar_t3_ox8: got %h expected 864", pixel_out);
        end
    endtask

    task automatic test_fire();
        @(negedge clock);
        vsync = 1'b1;
        reset = 1'b1;
        object_grid[2][3] = G_FIRE;
        @(negedge clock);
        reset = 1'b0;
        repeat (7) vsync_pulse();
        put_pixel(192, 224);
        checks++;
        if (pixel_out !== 12'hF00) begin
            errors++; $display("FAIL fire_7: got %h expected F00", pixel_out);
        end
        vsync_pulse();
        put_pixel(192, 224);
        checks++;
        if (pixel_out !== 12'hF80) begin
            errors++; $display("FAIL fire_8: got %h expected F80", pixel_out);
        end
        repeat (8) vsync_pulse();
        put_pixel(192, 224);
        checks++;
        if (pixel_out !== 12'hF00) begin
            errors++; $display("FAIL fire_16: got %h expected F00", pixel_out);
        end
    endtask

    task automatic test_sync_random();
        logic hs_h [0:999];
        logic vs_h [0:999];
        logic bl_h [0:999];
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            hs_h[i] = 1'($urandom);
            vs_h[i] = 1'($urandom);
            bl_h[i] = 1'($urandom);
            hsync  = hs_h[i];
            vsync  = vs_h[i];
            blank  = bl_h[i];
            hcount = 11'($urandom_range(100, 380));
            vcount = 10'($urandom_range(100, 540));
            @(posedge clock);
            #1;
            if (i >= 2) begin
                checks++;
                if ({hsync_out, vsync_out, blank_out} !== {hs_h[i-2], vs_h[i-2], bl_h[i-2]}) begin
                    errors++; $display("FAIL sync_delay cyc %0d: got hs=%b vs=%b bl=%b expected %b %b %b",
                                       i, hsync_out, vsync_out, blank_out, hs_h[i-2], vs_h[i-2], bl_h[i-2]);
                end
                if (bl_h[i-2]) begin
                    checks++;
                    if (pixel_out !== 12'h000) begin
                        errors++; $display("FAIL blank_black cyc %0d: got %h expected 000", i, pixel_out);
                    end
                end
            end
        end
        @(negedge clock);
        hsync = 1'b1; vsync = 1'b1; blank = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        hcount = '0; vcount = '0;
        hsync = 1'b1; vsync = 1'b1; blank = 1'b0;
        object_grid = '0;
        time_grid = '0;
        repeat (2) @(posedge clock);
        test_reset();
        test_boundary();
        test_onion();
        test_progress_bar();
        test_objects();
        test_fire();
        test_sync_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
